uart_block_assembler: RTL

UART_BLOCK_ASSEMBLER -- requirements
Module: uart_block_assembler

---
 rtl/uart_block_assembler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_block_assembler.sv
// Collects UART bytes into 512-bit big-endian blocks behind a one-deep output register.
// Optional idle timeout enabled by defining UART_BLOCK_TIMEOUT_EN.
module uart_block_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         rx_done_i,
    input  logic [7:0]   rx_data_i,
    input  logic         block_ready_i,
    output logic         block_valid_o,
    output logic [511:0] block_data_o,
    output logic [6:0]   byte_count_o,
    output logic         overflow_o,
    output logic         timeout_flag_o
);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t         state_q;
    logic [511:0]   buf_q;
    logic [511:0]   out_q;
    logic [6:0]     count_q;
    logic           valid_q;
    logic           ovf_q;
    logic [511:0]   filled_d;
    logic [5:0]     slot_s;
    logic           drain_s;
    logic           free_s;
    logic           expire_s;

    // Buffer image with the incoming byte merged into the next free slot
    always_comb begin
        slot_s   = 6'd63 - count_q[5:0];
        filled_d = buf_q;
        filled_d[{slot_s, 3'b000} +: 8] = rx_data_i;
        drain_s  = valid_q & block_ready_i;
        free_s   = ~valid_q | block_ready_i;
    end

`ifdef UART_BLOCK_TIMEOUT_EN
    localparam logic [23:0] TERM_C = 24'(TIMEOUT_CYCLES - 32'd1);

    logic [23:0] idle_q;
    logic        tflag_q;

    always_comb begin
        expire_s = (state_q == FILL) && !rx_done_i && (count_q != 7'd0) && (idle_q == TERM_C);
    end

    // Idle counter runs only while a partial block is held; any accepted byte restarts it
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idle_q  <= 24'd0;
            tflag_q <= 1'b0;
        end else begin
            tflag_q <= expire_s;
            if ((state_q == FILL) && rx_done_i) begin
                idle_q <= 24'd0;
            end else if ((state_q == FILL) && (count_q != 7'd0) && !expire_s) begin
                idle_q <= idle_q + 24'd1;
            end else begin
                idle_q <= 24'd0;
            end
        end
    end

    assign timeout_flag_o = tflag_q;
`else
    always_comb begin
        expire_s = 1'b0;
    end

    assign timeout_flag_o = 1'b0;
`endif

    // Assembly FSM together with the output register and sticky overflow
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= FILL;
            buf_q   <= 512'd0;
            out_q   <= 512'd0;
            count_q <= 7'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (rx_done_i) begin
                        buf_q <= filled_d;
                        if (count_q == 7'd63) begin
                            if (free_s) begin
                                out_q   <= filled_d;
                                valid_q <= 1'b1;
                                count_q <= 7'd0;
                            end else begin
                                state_q <= FULL;
                                count_q <= 7'd64;
                            end
                        end else begin
                            count_q <= count_q + 7'd1;
                            if (drain_s) begin
                                valid_q <= 1'b0;
                            end
                        end
                    end else begin
                        if (drain_s) begin
                            valid_q <= 1'b0;
                        end
                        if (expire_s) begin
                            count_q <= 7'd0;
                        end
                    end
                end
                FULL: begin
                    // Bytes are never accepted here, not even on the transfer edge
                    if (rx_done_i) begin
                        ovf_q <= 1'b1;
                    end
                    if (drain_s) begin
                        out_q   <= buf_q;
                        state_q <= FILL;
                        count_q <= 7'd0;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign block_valid_o = valid_q;
    assign block_data_o  = out_q;
    assign byte_count_o  = count_q;
    assign overflow_o    = ovf_q;

endmodule
